// File: rtl/tweak_load_ctrl_pkg.sv
// Shared definitions for the tweak buffer load controller: sequencer
// states and the default word/round geometry of SKINNY-128-384+.
package tweak_pkg;

  localparam int TWEAK_WORDS   = 4;
  localparam int SKINNY_ROUNDS = 40;
  localparam int RND_CNT_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CRCT,
    ST_DONE
  } tweak_state_e;

endpackage

// File: rtl/tweak_load_ctrl_cnt.sv
// Clear/increment counter with a terminal-count flag. Used by the tweak
// load controller for both the word count and the round index.
module tweak_cnt #(
  parameter int W    = 6,
  parameter int TERM = 39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == W'(TERM));

endmodule

// File: rtl/tweak_load_ctrl.sv
// Sequencer for the 128-bit tweak serial-to-parallel buffer. Shifts in
// WORDS tweak words (wr), reloads from the core every round (en), then
// loads the corrected tweak once (crct) and pulses done.
// Optional macro TWEAK_CTRL_ABORT_EN adds an abort input that returns
// the sequencer to IDLE from any state.
module tweak_load_ctrl
  import tweak_pkg::*;
#(
  parameter int WORDS  = TWEAK_WORDS,
  parameter int ROUNDS = SKINNY_ROUNDS,
  parameter int CNT_W  = RND_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pdi_valid,
  output logic             pdi_ready,
  output logic             wr,
  output logic             en,
  output logic             crct,
  output logic [CNT_W-1:0] rnd_idx,
  output logic             busy,
  output logic             done
`ifdef TWEAK_CTRL_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int WCNT_W = $clog2(WORDS + 1);

  tweak_state_e state_q;
  logic         busy_q, en_q, crct_q, done_q;
  logic         abort_w;
  logic         accept;
  logic         wterm, rterm;
  logic         wcnt_clr, rcnt_clr, rcnt_inc;
  logic [WCNT_W-1:0] wcnt_unused;

`ifdef TWEAK_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Handshake is only open in LOAD; abort closes it in the same cycle.
  assign pdi_ready = (state_q == ST_LOAD) && !abort_w;
  assign accept    = pdi_ready && pdi_valid;
  assign wr        = accept;

  // Word count lives only across LOAD; it is held at zero elsewhere.
  assign wcnt_clr = (state_q == ST_IDLE) || abort_w || (accept && wterm);

  tweak_cnt #(
    .W    (WCNT_W),
    .TERM (WORDS - 1)
  ) u_word_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (wcnt_clr),
    .inc_i  (accept),
    .cnt_o  (wcnt_unused),
    .term_o (wterm)
  );

  // Round index is zero until RUN, saturates at ROUNDS-1 through CRCT and
  // DONE, and is cleared again on the way back to IDLE.
  assign rcnt_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                    (state_q == ST_DONE) || abort_w;
  assign rcnt_inc = (state_q == ST_RUN) && !rterm;

  tweak_cnt #(
    .W    (CNT_W),
    .TERM (ROUNDS - 1)
  ) u_rnd_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (rcnt_clr),
    .inc_i  (rcnt_inc),
    .cnt_o  (rnd_idx),
    .term_o (rterm)
  );

  // Sequencer FSM; the Moore outputs are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      crct_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      crct_q <= 1'b0;
      done_q <= 1'b0;
      if (abort_w) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (accept && wterm) begin
              state_q <= ST_RUN;
              en_q    <= 1'b1;
            end
          end
          ST_RUN: begin
            if (rterm) begin
              state_q <= ST_CRCT;
              crct_q  <= 1'b1;
            end else begin
              en_q <= 1'b1;
            end
          end
          ST_CRCT: begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Abort masks the buffer strobes in the cycle it is raised.
  assign en   = en_q && !abort_w;
  assign crct = crct_q && !abort_w;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: doc/tweak_load_ctrl.md
# tweak_load_ctrl

Sequencer that drives the 128-bit tweak serial-to-parallel buffer in the DOM1 Romulus-N datapath. Accepts four 32-bit tweak words over a valid/ready handshake and issues one `wr` shift strobe per accepted word. Then holds `en` for every SKINNY round so the buffer reloads the next round tweakey from the core, and finishes with a single `crct` strobe that loads the corrected tweak from the mode logic. It sits directly upstream of the tweak buffer and owns its three load-select lines.

## Interface
- `WORDS`, 4, number of 32-bit words per 128-bit tweak
- `ROUNDS`, 40, SKINNY-128-384+ rounds per block
- `CNT_W`, 6, width of round counter and `rnd_idx`; must satisfy 2^CNT_W ≥ ROUNDS
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request one tweak load/run/correct sequence; sampled only in IDLE
- `pdi_valid`  in  1  upstream word available on the buffer's `pdi` bus
- `pdi_ready`  out  1  controller accepts a word this cycle
- `wr`  out  1  buffer shift-in strobe
- `en`  out  1  buffer load-from-core strobe
- `crct`  out  1  buffer load-from-mode strobe
- `rnd_idx`  out  CNT_W  current round index, 0..ROUNDS-1
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `abort`  in  1  return to IDLE; present only with `TWEAK_CTRL_ABORT_EN`

## Operation
- States: IDLE, LOAD, RUN, CRCT, DONE.
- IDLE: all strobes low. `start`=1 → LOAD, word counter cleared.
- LOAD:
  - `pdi_ready`=1.
  - `wr` = `pdi_valid & pdi_ready` (Mealy output).
  - Word counter increments per accepted word.
  - Accepting word WORDS-1 → RUN, `rnd_idx` cleared.
  - `pdi_valid`=0 stalls the state with `wr`=0, and the count is held.
- RUN:
  - `en`=1 every cycle (Moore output).
  - `rnd_idx` increments each cycle.
  - At `rnd_idx`=ROUNDS-1 → CRCT; `rnd_idx` holds at ROUNDS-1.
- CRCT: `crct`=1 for exactly one cycle → DONE.
- DONE: `done`=1 for one cycle → IDLE. `rnd_idx` clears on entry to IDLE.
- Strobe exclusivity: `wr`, `en` and `crct` are never high together. The buffer's wr>en>crct priority is therefore never exercised.
- `start` outside IDLE is ignored and not queued. `start` held high in DONE is seen in IDLE on the next cycle.
- `pdi_ready` is low outside LOAD; `pdi_valid` there has no effect.
- Reset (any time, including mid-sequence):
  - State goes to IDLE; counters go to 0.
  - `pdi_ready`, `wr`, `en`, `crct`, `busy`, `done` = 0; `rnd_idx` = 0.
  - The buffer contents are not cleared by this block.

## Timing
- Reference case: `start` high at cycle 0, no stalls.
  - LOAD: cycles 1–4, `wr` high cycles 1–4.
  - RUN: cycles 5–44, `en` high 40 cycles, `rnd_idx` 0..39.
  - CRCT: cycle 45.
  - DONE: cycle 46.
  - IDLE: cycle 47.
- Latency from `start` to `done` = WORDS + ROUNDS + 2 cycles, plus one cycle per LOAD stall.
- Every output except `wr`/`pdi_ready` is registered-state decoded; `wr` is combinational from `pdi_valid`.
- Back-to-back: `start` high at cycle 47 re-enters LOAD at cycle 48.

## Configuration
- `TWEAK_CTRL_ABORT_EN` defined:
  - Adds the `abort` port. `abort`=1 in any state → IDLE on the next edge.
  - In the same cycle `wr`, `en`, `crct` and `pdi_ready` are forced 0.
  - Counters clear and `done` is not pulsed.
  - `abort` has priority over `start`.
- Undefined: no `abort` port; a sequence once started always runs to DONE.

## Structure
- Shared package `tweak_pkg`: state enum (IDLE, LOAD, RUN, CRCT, DONE), `TWEAK_WORDS`=4, `SKINNY_ROUNDS`=40, round-counter width constant.
- One sub-module: `tweak_cnt`, a clear/increment/terminal-flag counter. It is instantiated twice: word counter and round counter.

## Test plan
- Reset mid-RUN (`rst_n` low at `rnd_idx`=17) → every output 0 immediately. With `start` high after release, LOAD is entered on the first clock edge after release.
- No stalls: `start` at cycle 0 with `pdi_valid` constant high → `wr` exactly 4 cycles, `en` 40 cycles, `crct` 1 cycle at 45, `done` at 46. The strobes are mutually exclusive every cycle.
- Stalls in LOAD: `pdi_valid` pattern 1,0,0,1,1,0,1 → `wr` exactly 4 cycles, aligned with valid high. RUN starts the cycle after the 4th accept, and `done` is delayed by 3 cycles.
- `start` pulsed during RUN and CRCT → ignored; exactly one `done`. A second `start` in IDLE runs a full second sequence.
- With `TWEAK_CTRL_ABORT_EN`: `abort` in LOAD after 2 words → IDLE next cycle, no `done`, `rnd_idx`=0. `abort` and `start` together in IDLE → stays IDLE.
- Check `rnd_idx` equals 0..39 across consecutive `en` cycles. Check `busy` is high from cycle 1 through 46 and low at 47.
